// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: FSM state encodings and port indices.
package mem_arb_pkg;
  localparam int NPORTS = 2;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;  // no read outstanding
  localparam logic [1:0] ST_RD   = 2'd1;  // read data arriving this cycle
  localparam logic [1:0] ST_HOLD = 2'd2;  // read data held in memory, awaiting rsp_ready
endpackage

// File: rtl/mem_arb_pick.sv
// Two-way selector: the pointed port wins when eligible, otherwise the other port.
// Fixed priority is obtained by tying ptr_i to the preferred port.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] elig_i,
  input  logic              ptr_i,
  output logic [NPORTS-1:0] gnt_o
);
  // one-hot grant, pointed port first
  always_comb begin
    gnt_o = '0;
    if (elig_i[ptr_i])       gnt_o[ptr_i]  = 1'b1;
    else if (elig_i[~ptr_i]) gnt_o[~ptr_i] = 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter in front of the single-ported memory.
// One request forwarded per cycle; read data comes back from the memory's own
// read register and is held there (no local copy) until the owner accepts it.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise port 1
// (data) has fixed priority over port 0 (instruction).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPORTS-1:0]              req_valid_i,
  output logic [NPORTS-1:0]              req_ready_o,
  input  logic [NPORTS-1:0]              req_we_i,
  input  logic [NPORTS-1:0][ADDR_W-1:0]  req_addr_i,
  input  logic [NPORTS-1:0][3:0]         req_wmask_i,
  input  logic [NPORTS-1:0][31:0]        req_wdata_i,
  output logic [NPORTS-1:0]              rsp_valid_o,
  input  logic [NPORTS-1:0]              rsp_ready_i,
  output logic [31:0]                    rsp_rdata_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  output logic                           mem_rstrb_o,
  output logic [3:0]                     mem_wmask_o,
  output logic [31:0]                    mem_wdata_o,
  input  logic [31:0]                    mem_rdata_i
);
  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              run_q, run_d;
  logic              en, busy, can_rd, sel, any_gnt, rd_gnt, pick_ptr;
  logic [NPORTS-1:0] elig, gnt;

  // Grants are blocked while reset is low and for the first cycle after release.
  assign en   = rst & run_q;
  assign busy = (state_q != ST_IDLE);

  // A new read may issue only when the response path is free this cycle.
  always_comb begin
    can_rd = ~busy | rsp_ready_i[owner_q];
    for (int p = 0; p < NPORTS; p++)
      elig[p] = en & req_valid_i[p] & (req_we_i[p] | can_rd);
  end

  mem_arb_pick u_pick (
    .elig_i (elig),
    .ptr_i  (pick_ptr),
    .gnt_o  (gnt)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // Pointer moves off the pointed port once it has been served.
  always_comb ptr_d = gnt[ptr_q] ? ~ptr_q : ptr_q;

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = PORT_DATA;
`endif

  assign sel     = gnt[1];
  assign any_gnt = |gnt;
  assign rd_gnt  = any_gnt & ~req_we_i[sel];

  // Forward the granted request to memory; idle cycles drive zeros.
  always_comb begin
    req_ready_o = gnt;
    mem_addr_o  = any_gnt ? req_addr_i[sel]  : '0;
    mem_wdata_o = any_gnt ? req_wdata_i[sel] : '0;
    mem_rstrb_o = rd_gnt;
    mem_wmask_o = (any_gnt & req_we_i[sel]) ? req_wmask_i[sel] : 4'h0;
  end

  // Response to the owner of the outstanding read, straight from memory.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (busy && rst) begin
      rsp_valid_o[owner_q] = 1'b1;
      rsp_rdata_o          = mem_rdata_i;
    end
  end

  // FSM next state: new read wins, else retire or hold the outstanding one.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    run_d   = 1'b1;
    if (rd_gnt) begin
      state_d = ST_RD;
      owner_d = sel;
    end else if (busy) begin
      state_d = rsp_ready_i[owner_q] ? ST_IDLE : ST_HOLD;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_IF;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      run_q   <= run_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioral registered-read memory.
module tb_mem_arbiter;
  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [1:0][3:0]   req_wmask;
  logic [31:0]       rsp_rdata, mem_addr, mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;
  logic              mem_rstrb;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_arr [0:63];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wmask_i (req_wmask),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .mem_addr_o  (mem_addr),
    .mem_rstrb_o (mem_rstrb),
    .mem_wmask_o (mem_wmask),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // memory: read register loads only on strobe, byte-masked writes
  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= mem_arr[mem_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) mem_arr[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 2'b00;
    req_we    = 2'b00;
    rsp_ready = 2'b11;
  endtask

  task automatic drv(input int p, input logic we, input logic [31:0] addr,
                     input logic [3:0] mask, input logic [31:0] data);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_addr[p]  = addr;
    req_wmask[p] = mask;
    req_wdata[p] = data;
  endtask

  logic [1:0] prev_gnt;

  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
    req_addr = '0; req_wmask = '0; req_wdata = '0;
    idle();

    // reset with both ports requesting
    rst = 1'b0;
    drv(0, 1'b0, 32'h10, 4'h0, 32'h0);
    drv(1, 1'b0, 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    chk("rst_ready", {30'h0, req_ready}, 32'h0);
    chk("rst_rvalid", {30'h0, rsp_valid}, 32'h0);
    chk("rst_rstrb", {31'h0, mem_rstrb}, 32'h0);
    chk("rst_wmask", {28'h0, mem_wmask}, 32'h0);
    step();
    step();
    rst = 1'b1;
    idle();
    step();
    step();

    // port 1 write DEADBEEF to 0x10
    drv(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_ready", {30'h0, req_ready}, 32'h2);
    chk("wr_wmask", {28'h0, mem_wmask}, 32'hF);
    chk("wr_addr", mem_addr, 32'h10);
    chk("wr_rstrb", {31'h0, mem_rstrb}, 32'h0);
    step();
    idle();
    drv(0, 1'b0, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    chk("rd0_ready", {30'h0, req_ready}, 32'h1);
    chk("rd0_rstrb", {31'h0, mem_rstrb}, 32'h1);
    step();
    idle();
    @(negedge clk);
    chk("rd0_rvalid", {30'h0, rsp_valid}, 32'h1);
    chk("rd0_rdata", rsp_rdata, 32'hDEADBEEF);
    step();

    // held response while port 1 writes, then port 1 read stalls until accept
    drv(0, 1'b0, 32'h10, 4'h0, 32'h0);
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("hold_issue", {30'h0, req_ready}, 32'h1);
    step();
    idle();
    rsp_ready = 2'b00;
    drv(1, 1'b1, 32'h10, 4'hF, 32'h55555555);
    @(negedge clk);
    chk("hold_wr_ready", {30'h0, req_ready}, 32'h2);
    chk("hold_rvalid_a", {30'h0, rsp_valid}, 32'h1);
    chk("hold_rdata_a", rsp_rdata, 32'hDEADBEEF);
    step();
    drv(1, 1'b0, 32'h10, 4'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_stall_ready", {30'h0, req_ready}, 32'h0);
      chk("hold_rvalid", {30'h0, rsp_valid}, 32'h1);
      chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
      step();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("hold_accept_ready", {30'h0, req_ready}, 32'h2);
    chk("hold_accept_rdata", rsp_rdata, 32'hDEADBEEF);
    step();
    idle();
    @(negedge clk);
    chk("rd1_rvalid", {30'h0, rsp_valid}, 32'h2);
    chk("rd1_rdata", rsp_rdata, 32'h55555555);
    step();

    // restore DEADBEEF, byte-mask write, read back
    drv(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    step();
    idle();
    drv(0, 1'b1, 32'h10, 4'h2, 32'h0000AB00);
    @(negedge clk);
    chk("bm_wmask", {28'h0, mem_wmask}, 32'h2);
    step();
    idle();
    drv(1, 1'b0, 32'h10, 4'h0, 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("bm_rvalid", {30'h0, rsp_valid}, 32'h2);
    chk("bm_rdata", rsp_rdata, 32'hDEADABEF);
    step();

    // both ports read every cycle, responses always accepted
    drv(0, 1'b0, 32'h10, 4'h0, 32'h0);
    drv(1, 1'b0, 32'h10, 4'h0, 32'h0);
    prev_gnt = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("rr_onehot", {31'h0, (req_ready == 2'b01) || (req_ready == 2'b10)}, 32'h1);
      if (i > 0) chk("rr_alt", {30'h0, req_ready}, {30'h0, ~prev_gnt});
      if (i > 0) chk("rr_rvalid", {30'h0, rsp_valid}, {30'h0, prev_gnt});
`else
      chk("fp_ready", {30'h0, req_ready}, 32'h2);
      if (i > 0) chk("fp_rvalid", {30'h0, rsp_valid}, 32'h2);
`endif
      prev_gnt = req_ready;
      step();
    end
    idle();
    step();
    step();

    // reset during HOLD discards the response
    drv(0, 1'b0, 32'h10, 4'h0, 32'h0);
    rsp_ready = 2'b00;
    step();
    idle();
    rsp_ready = 2'b00;
    step();
    @(negedge clk);
    chk("rh_hold_rvalid", {30'h0, rsp_valid}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rh_rst_rvalid", {30'h0, rsp_valid}, 32'h0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rh_after_rvalid", {30'h0, rsp_valid}, 32'h0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
